// File: rtl/seg_pkg.sv
// Shared constants, state encoding and BCD helper for the seven-segment scanner.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] CODE_MINUS = 4'b1111;

    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_TENS = 4'b1101;
    localparam logic [3:0] AN_HUND = 4'b1011;
    localparam logic [3:0] AN_SIGN = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } state_t;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/sdcc.sv
// Seven-segment decoder: BCD digit or minus code to active-low {a,b,c,d,e,f,g}.
module sdcc
    import seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       en,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (en) begin
            case (code)
                4'd0:       seg = 7'b0000001;
                4'd1:       seg = 7'b1001111;
                4'd2:       seg = 7'b0010010;
                4'd3:       seg = 7'b0000110;
                4'd4:       seg = 7'b1001100;
                4'd5:       seg = 7'b0100100;
                4'd6:       seg = 7'b0100000;
                4'd7:       seg = 7'b0001111;
                4'd8:       seg = 7'b0000000;
                4'd9:       seg = 7'b0000100;
                CODE_MINUS: seg = 7'b1111110;
                default:    seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg_display_scanner_bcd_dabble.sv
// Sequential double-dabble converter: signed value to sign + three BCD digits.
module bcd_dabble
    import seg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             commit,
    output logic             sign,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    localparam logic [3:0] LAST_ITER = 4'(WIDTH);

    state_t           state, state_next;
    logic [WIDTH:0]   mag, mag_in, ext;
    logic [11:0]      bcd, bcd_adj;
    logic [3:0]       iter;

    // One extra magnitude bit so the most negative input still has a positive magnitude.
    always_comb begin
        ext    = {value[WIDTH-1], value};
        mag_in = value[WIDTH-1] ? ('0 - ext) : ext;
    end

    always_comb begin
        bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (load) state_next = ST_CONV;
            ST_CONV:   if (iter == LAST_ITER) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign <= 1'b0;
            mag  <= '0;
            bcd  <= '0;
            iter <= '0;
        end else if (state == ST_IDLE && load) begin
            sign <= value[WIDTH-1];
            mag  <= mag_in;
            bcd  <= '0;
            iter <= '0;
        end else if (state == ST_CONV) begin
            bcd  <= {bcd_adj[10:0], mag[WIDTH]};
            mag  <= {mag[WIDTH-1:0], 1'b0};
            iter <= iter + 4'd1;
        end
    end

    assign busy     = (state != ST_IDLE);
    assign commit   = (state == ST_COMMIT);
    assign hundreds = bcd[11:8];
    assign tens     = bcd[7:4];
    assign ones     = bcd[3:0];

endmodule

// File: rtl/seg_display_scanner.sv
// Signed-value display driver: background BCD conversion plus 4-digit multiplexed scan.
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic [6:0]       seg,
    output logic [3:0]       an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic       commit, conv_sign;
    logic [3:0] conv_h, conv_t, conv_o;
    logic       disp_sign;
    logic [3:0] disp_h, disp_t, disp_o;
    logic [CW-1:0] refresh_cnt;
    logic [1:0] sel;
    logic [3:0] code;
    logic       en;

    bcd_dabble #(.WIDTH(WIDTH)) u_dabble (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .busy     (busy),
        .commit   (commit),
        .sign     (conv_sign),
        .hundreds (conv_h),
        .tens     (conv_t),
        .ones     (conv_o)
    );

    // Display registers change only on commit, so a scan never mixes old and new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_sign <= 1'b0;
            disp_h    <= '0;
            disp_t    <= '0;
            disp_o    <= '0;
        end else if (commit) begin
            disp_sign <= conv_sign;
            disp_h    <= conv_h;
            disp_t    <= conv_t;
            disp_o    <= conv_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            sel         <= '0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            sel         <= sel + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_comb begin
        code = disp_o;
        en   = 1'b1;
        an   = AN_ONES;
        case (sel)
            2'd0: begin
                code = disp_o;
                en   = 1'b1;
                an   = AN_ONES;
            end
            2'd1: begin
                code = disp_t;
                en   = (disp_h != 4'd0) || (disp_t != 4'd0);
                an   = AN_TENS;
            end
            2'd2: begin
                code = disp_h;
                en   = (disp_h != 4'd0);
                an   = AN_HUND;
            end
            default: begin
                code = CODE_MINUS;
                en   = disp_sign;
                an   = AN_SIGN;
            end
        endcase
    end

    sdcc u_sdcc (
        .code (code),
        .en   (en),
        .seg  (seg)
    );

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with WIDTH=8 and a short refresh period.
module tb_seg_display_scanner;
    import seg_pkg::*;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                           S7 = 7'b0001111, S8 = 7'b0000000, SM = 7'b1111110,
                           SB = 7'b1111111;

    logic       clk, rst_n, load, busy;
    logic [7:0] value;
    logic [6:0] seg;
    logic [3:0] an;

    int tests = 0;
    int fails = 0;

    seg_display_scanner #(.WIDTH(8), .REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (value),
        .busy  (busy),
        .seg   (seg),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       value;
        logic [3:0][6:0]  exp;   // index = digit select 0..3
    } vec_t;

    function automatic vec_t mk(input logic [7:0] v, input logic [6:0] e0, e1, e2, e3);
        vec_t r;
        r.value  = v;
        r.exp[0] = e0;
        r.exp[1] = e1;
        r.exp[2] = e2;
        r.exp[3] = e3;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load  = 1'b1;
        value = v;
        step();
        load  = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic check_digit(input string name, input int k, input logic [6:0] exp);
        logic [3:0] pat;
        int n;
        case (k)
            0:       pat = AN_ONES;
            1:       pat = AN_TENS;
            2:       pat = AN_HUND;
            default: pat = AN_SIGN;
        endcase
        n = 0;
        while (an !== pat && n < 20) begin
            step();
            n++;
        end
        if (an !== pat) check({name, "_an_timeout"}, {28'd0, an}, {28'd0, pat});
        else            check(name, {25'd0, seg}, {25'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    vec_t vecs[7];
    int   nb;

    initial begin
        vecs[0] = mk(8'd123, S3, S2, S1, SB);
        vecs[1] = mk(8'h80,  S8, S2, S1, SM);
        vecs[2] = mk(8'hFB,  S5, SB, SB, SM);
        vecs[3] = mk(8'd100, S0, S0, S1, SB);
        vecs[4] = mk(8'd10,  S0, S1, SB, SB);
        vecs[5] = mk(8'd127, S7, S2, S1, SB);
        vecs[6] = mk(8'hFF,  S1, SB, SB, SM);

        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        #1;
        check("rst_an",   {28'd0, an},   {28'd0, 4'b1110});
        check("rst_seg",  {25'd0, seg},  {25'd0, S0});
        check("rst_busy", {31'd0, busy}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("scan_hold_an", {28'd0, an}, {28'd0, 4'b1110});
        step();
        check("scan_adv_an",  {28'd0, an},  {28'd0, 4'b1101});
        check("scan_adv_seg", {25'd0, seg}, {25'd0, SB});

        for (int i = 0; i < 7; i++) begin
            do_load(vecs[i].value);
            check($sformatf("v%0d_busy_set", i), {31'd0, busy}, 32'd1);
            count_busy(nb);
            check($sformatf("v%0d_busy_len", i), nb, 32'd10);
            for (int k = 0; k < 4; k++)
                check_digit($sformatf("v%0d_d%0d", i, k), k, vecs[i].exp[k]);
        end

        // A second load while busy must be ignored entirely.
        do_load(8'd7);
        step();
        do_load(8'd9);
        count_busy(nb);
        check("ign_busy_len", nb, 32'd8);
        repeat (12) begin
            step();
            check("ign_no_restart", {31'd0, busy}, 32'd0);
        end
        check_digit("ign_d0", 0, S7);
        check_digit("ign_d1", 1, SB);
        check_digit("ign_d3", 3, SB);

        // Asynchronous reset during conversion aborts and clears the display.
        do_load(8'd99);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_an",   {28'd0, an},   {28'd0, 4'b1110});
        check("abort_seg",  {25'd0, seg},  {25'd0, S0});
        step();
        rst_n = 1'b1;
        step();
        do_load(8'd42);
        count_busy(nb);
        check("post_busy_len", nb, 32'd10);
        check_digit("post_d0", 0, S2);
        check_digit("post_d1", 1, S4);
        check_digit("post_d2", 2, SB);
        check_digit("post_d3", 3, SB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
